// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and the register-file writeback entry type.
package mips_pkg;

   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;

   localparam logic [AW-1:0] REG_ZERO = 5'd0;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          kill;
   } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of pending long-latency writebacks.
// Supports per-entry kill on address match and a live-address decode.
module wb_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = 5,
   parameter int unsigned DW    = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_push,
   input  logic [AW-1:0]             i_push_addr,
   input  logic [DW-1:0]             i_push_data,
   input  logic                      i_pop,
   input  logic                      i_kill_en,
   input  logic [AW-1:0]             i_kill_addr,
   output logic [AW-1:0]             o_head_addr,
   output logic [DW-1:0]             o_head_data,
   output logic                      o_head_kill,
   output logic [2**AW-1:0]          o_pending,
   output logic [$clog2(DEPTH):0]    o_count,
   output logic                      o_full,
   output logic                      o_empty
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [AW-1:0]    r_addr [DEPTH];
   logic [DW-1:0]    r_data [DEPTH];
   logic [DEPTH-1:0] r_valid;
   logic [DEPTH-1:0] r_kill;
   logic [PW-1:0]    r_rptr;
   logic [PW-1:0]    r_wptr;
   logic [PW:0]      r_count;
   logic [2**AW-1:0] w_pending;

   // Payload needs no reset: occupancy is tracked by r_valid.
   always_ff @(posedge clk) begin
      if (i_push) begin
         r_addr[r_wptr] <= i_push_addr;
         r_data[r_wptr] <= i_push_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= '0;
         r_kill  <= '0;
         r_rptr  <= '0;
         r_wptr  <= '0;
         r_count <= '0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (i_kill_en && r_valid[PW'(i)] && (r_addr[PW'(i)] == i_kill_addr))
               r_kill[PW'(i)] <= 1'b1;
         end
         if (i_pop) begin
            r_valid[r_rptr] <= 1'b0;
            r_kill[r_rptr]  <= 1'b0;
            r_rptr          <= r_rptr + 1'b1;
         end
         // The pushed slot is written last so a same-cycle kill never hits the younger entry.
         if (i_push) begin
            r_valid[r_wptr] <= 1'b1;
            r_kill[r_wptr]  <= 1'b0;
            r_wptr          <= r_wptr + 1'b1;
         end
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_comb begin
      w_pending = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (r_valid[PW'(i)] && !r_kill[PW'(i)])
            w_pending[r_addr[PW'(i)]] = 1'b1;
      end
      w_pending[0] = 1'b0;
   end

   assign o_pending   = w_pending;
   assign o_head_addr = r_addr[r_rptr];
   assign o_head_data = r_data[r_rptr];
   assign o_head_kill = r_kill[r_rptr];
   assign o_count     = r_count;
   assign o_full      = (r_count == (PW+1)'(DEPTH));
   assign o_empty     = (r_count == '0);

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write port owner: ALU writeback has priority, long-latency
// results are buffered and drained in idle ALU cycles, with WAW kill.
module rf_write_arbiter #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = mips_pkg::AW,
   parameter int unsigned DW    = mips_pkg::DW
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   alu_we,
   input  logic [AW-1:0]          alu_waddr,
   input  logic [DW-1:0]          alu_wdata,
   input  logic                   lu_valid,
   output logic                   lu_ready,
   input  logic [AW-1:0]          lu_waddr,
   input  logic [DW-1:0]          lu_wdata,
   output logic                   we,
   output logic [AW-1:0]          waddr,
   output logic [DW-1:0]          wdata,
   output logic [2**AW-1:0]       pending,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   import mips_pkg::*;

   logic          w_alu_wr;
   logic          w_enq;
   logic          w_push;
   logic          w_pop;
   logic          w_full;
   logic          w_empty;
   logic          w_head_kill;
   logic [AW-1:0] w_head_addr;
   logic [DW-1:0] w_head_data;

   assign w_alu_wr = !rst && alu_we && (alu_waddr != AW'(REG_ZERO));
   assign lu_ready = !w_full && !rst;
   assign w_enq    = lu_valid && lu_ready;
   assign w_push   = w_enq && (lu_waddr != AW'(REG_ZERO));
   // A killed head drains silently even while the ALU owns the port.
   assign w_pop    = !w_empty && (w_head_kill || !w_alu_wr);

   wb_fifo #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (DW)
   ) u_wb_fifo (
      .clk         (clk),
      .rst         (rst),
      .i_push      (w_push),
      .i_push_addr (lu_waddr),
      .i_push_data (lu_wdata),
      .i_pop       (w_pop),
      .i_kill_en   (w_alu_wr),
      .i_kill_addr (alu_waddr),
      .o_head_addr (w_head_addr),
      .o_head_data (w_head_data),
      .o_head_kill (w_head_kill),
      .o_pending   (pending),
      .o_count     (count),
      .o_full      (w_full),
      .o_empty     (w_empty)
   );

   always_comb begin
      we    = 1'b0;
      waddr = '0;
      wdata = '0;
      if (w_alu_wr) begin
         we    = 1'b1;
         waddr = alu_waddr;
         wdata = alu_wdata;
      end else if (!rst && !w_empty && !w_head_kill) begin
         we    = 1'b1;
         waddr = w_head_addr;
         wdata = w_head_data;
      end
   end

   assign full  = w_full;
   assign empty = w_empty;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter with a register-file model on the write port.
module tb_rf_write_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        alu_we;
   logic [4:0]  alu_waddr;
   logic [31:0] alu_wdata;
   logic        lu_valid;
   logic        lu_ready;
   logic [4:0]  lu_waddr;
   logic [31:0] lu_wdata;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic [31:0] pending;
   logic [2:0]  count;
   logic        full;
   logic        empty;

   logic [31:0] rf [32];
   int checks = 0;
   int errors = 0;

   rf_write_arbiter #(.DEPTH(4), .AW(5), .DW(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .alu_we    (alu_we),
      .alu_waddr (alu_waddr),
      .alu_wdata (alu_wdata),
      .lu_valid  (lu_valid),
      .lu_ready  (lu_ready),
      .lu_waddr  (lu_waddr),
      .lu_wdata  (lu_wdata),
      .we        (we),
      .waddr     (waddr),
      .wdata     (wdata),
      .pending   (pending),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (!rst && we) rf[waddr] <= wdata;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alu_we = 1'b0; alu_waddr = 5'd0; alu_wdata = 32'd0;
      lu_valid = 1'b0; lu_waddr = 5'd0; lu_wdata = 32'd0;
   endtask

   task automatic test_reset();
      idle();
      #2;
      checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b expected 0", we); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %0b expected 1", empty); end
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b expected 0", full); end
      checks++; if (lu_ready !== 1'b0) begin errors++; $display("FAIL reset_lu_ready: got %0b expected 0", lu_ready); end
      checks++; if (pending !== 32'd0) begin errors++; $display("FAIL reset_pending: got %0h expected 0", pending); end
      cyc(); cyc();
      rst = 1'b0;
      #1;
      checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %0b expected 1", lu_ready); end
   endtask

   task automatic test_alu_priority();
      idle(); lu_valid = 1'b1; lu_waddr = 5'd9; lu_wdata = 32'd69;
      #1;
      checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL prio_ready: got %0b expected 1", lu_ready); end
      cyc();
      idle(); alu_we = 1'b1; alu_waddr = 5'd16; alu_wdata = 32'd1337;
      #1;
      checks++; if ({we, waddr, wdata} !== {1'b1, 5'd16, 32'd1337}) begin errors++; $display("FAIL prio_alu: got we=%0b waddr=%0d wdata=%0d expected 1/16/1337", we, waddr, wdata); end
      checks++; if (pending !== 32'h200) begin errors++; $display("FAIL prio_pending: got %0h expected 200", pending); end
      cyc();
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL prio_held: got count %0d expected 1", count); end
      idle();
      #1;
      checks++; if ({we, waddr, wdata} !== {1'b1, 5'd9, 32'd69}) begin errors++; $display("FAIL prio_drain: got we=%0b waddr=%0d wdata=%0d expected 1/9/69", we, waddr, wdata); end
      cyc();
      checks++; if (rf[16] !== 32'd1337) begin errors++; $display("FAIL prio_rf16: got %0d expected 1337", rf[16]); end
      checks++; if (rf[9] !== 32'd69) begin errors++; $display("FAIL prio_rf9: got %0d expected 69", rf[9]); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL prio_empty: got %0b expected 1", empty); end
   endtask

   task automatic test_full();
      for (int k = 1; k <= 4; k++) begin
         alu_we = 1'b1; alu_waddr = 5'd20; alu_wdata = 32'd2020;
         lu_valid = 1'b1; lu_waddr = 5'(k); lu_wdata = 32'(100 + k);
         cyc();
      end
      lu_waddr = 5'd5; lu_wdata = 32'd105;
      #1;
      checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag: got %0b expected 1", full); end
      checks++; if (lu_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b expected 0", lu_ready); end
      checks++; if (pending !== 32'h1E) begin errors++; $display("FAIL full_pending: got %0h expected 1e", pending); end
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", count); end
      checks++; if (waddr !== 5'd20) begin errors++; $display("FAIL full_alu_waddr: got %0d expected 20", waddr); end
      cyc();
      checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_hold: got count %0d expected 4", count); end
      alu_we = 1'b0;
      #1;
      checks++; if (lu_ready !== 1'b0) begin errors++; $display("FAIL full_no_enq_on_pop: got %0b expected 0", lu_ready); end
      checks++; if ({we, waddr, wdata} !== {1'b1, 5'd1, 32'd101}) begin errors++; $display("FAIL full_pop1: got we=%0b waddr=%0d wdata=%0d expected 1/1/101", we, waddr, wdata); end
      cyc();
      checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_after_pop: got count %0d expected 3", count); end
      checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL full_ready_again: got %0b expected 1", lu_ready); end
      checks++; if (waddr !== 5'd2) begin errors++; $display("FAIL full_pop2: got waddr %0d expected 2", waddr); end
      cyc();
      lu_valid = 1'b0;
      checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_push_pop: got count %0d expected 3", count); end
      checks++; if (pending !== 32'h38) begin errors++; $display("FAIL full_pending2: got %0h expected 38", pending); end
      for (int n = 0; n < 10 && !empty; n++) cyc();
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL full_drain_timeout: got empty %0b expected 1", empty); end
      for (int k = 1; k <= 5; k++) begin
         checks++; if (rf[k] !== 32'(100 + k)) begin errors++; $display("FAIL full_rf%0d: got %0d expected %0d", k, rf[k], 100 + k); end
      end
      checks++; if (rf[20] !== 32'd2020) begin errors++; $display("FAIL full_rf20: got %0d expected 2020", rf[20]); end
   endtask

   task automatic test_waw_kill();
      idle(); lu_valid = 1'b1; lu_waddr = 5'd7; lu_wdata = 32'd5;
      cyc();
      idle();
      #1;
      checks++; if (pending[7] !== 1'b1) begin errors++; $display("FAIL kill_pending_set: got %0b expected 1", pending[7]); end
      alu_we = 1'b1; alu_waddr = 5'd7; alu_wdata = 32'd99;
      #1;
      checks++; if ({we, waddr, wdata} !== {1'b1, 5'd7, 32'd99}) begin errors++; $display("FAIL kill_alu: got we=%0b waddr=%0d wdata=%0d expected 1/7/99", we, waddr, wdata); end
      cyc();
      checks++; if (pending !== 32'd0) begin errors++; $display("FAIL kill_pending_clr: got %0h expected 0", pending); end
      checks++; if (count !== 3'd1) begin errors++; $display("FAIL kill_count: got %0d expected 1", count); end
      idle();
      #1;
      checks++; if (we !== 1'b0) begin errors++; $display("FAIL kill_silent_pop: got we %0b expected 0", we); end
      cyc();
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL kill_popped: got empty %0b expected 1", empty); end
      checks++; if (rf[7] !== 32'd99) begin errors++; $display("FAIL kill_rf7: got %0d expected 99", rf[7]); end

      lu_valid = 1'b1; lu_waddr = 5'd7; lu_wdata = 32'd5;
      alu_we = 1'b1; alu_waddr = 5'd7; alu_wdata = 32'd99;
      cyc();
      idle();
      #1;
      checks++; if (pending !== 32'h80) begin errors++; $display("FAIL same_pending: got %0h expected 80", pending); end
      checks++; if ({we, waddr, wdata} !== {1'b1, 5'd7, 32'd5}) begin errors++; $display("FAIL same_drain: got we=%0b waddr=%0d wdata=%0d expected 1/7/5", we, waddr, wdata); end
      cyc();
      checks++; if (rf[7] !== 32'd5) begin errors++; $display("FAIL same_rf7: got %0d expected 5", rf[7]); end

      idle(); lu_valid = 1'b1; lu_waddr = 5'd8; lu_wdata = 32'd1;
      cyc();
      idle(); alu_we = 1'b1; alu_waddr = 5'd8; alu_wdata = 32'd2;
      cyc();
      alu_waddr = 5'd10; alu_wdata = 32'd3;
      #1;
      checks++; if ({we, waddr} !== {1'b1, 5'd10}) begin errors++; $display("FAIL killbusy_alu: got we=%0b waddr=%0d expected 1/10", we, waddr); end
      cyc();
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL killbusy_pop: got empty %0b expected 1", empty); end
      checks++; if (rf[8] !== 32'd2) begin errors++; $display("FAIL killbusy_rf8: got %0d expected 2", rf[8]); end
   endtask

   task automatic test_zero();
      idle(); alu_we = 1'b1; alu_waddr = 5'd0; alu_wdata = 32'd77;
      lu_valid = 1'b1; lu_waddr = 5'd0; lu_wdata = 32'd88;
      #1;
      checks++; if (we !== 1'b0) begin errors++; $display("FAIL zero_we: got %0b expected 0", we); end
      checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL zero_ready: got %0b expected 1", lu_ready); end
      cyc();
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL zero_count: got %0d expected 0", count); end
      idle(); lu_valid = 1'b1; lu_waddr = 5'd3; lu_wdata = 32'd33;
      cyc();
      idle(); alu_we = 1'b1; alu_waddr = 5'd0; alu_wdata = 32'd44;
      #1;
      checks++; if ({we, waddr, wdata} !== {1'b1, 5'd3, 32'd33}) begin errors++; $display("FAIL zero_alu_yields: got we=%0b waddr=%0d wdata=%0d expected 1/3/33", we, waddr, wdata); end
      cyc();
      checks++; if (rf[3] !== 32'd33) begin errors++; $display("FAIL zero_rf3: got %0d expected 33", rf[3]); end
      idle();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) begin
         idle(); lu_valid = 1'b1; lu_waddr = 5'(11 + i); lu_wdata = 32'(200 + i);
         #1;
         if (i > 0) begin
            checks++; if ({we, waddr, wdata} !== {1'b1, 5'(10 + i), 32'(199 + i)}) begin errors++; $display("FAIL wrap_write%0d: got we=%0b waddr=%0d wdata=%0d expected 1/%0d/%0d", i, we, waddr, wdata, 10 + i, 199 + i); end
         end
         cyc();
         checks++; if (count !== 3'd1) begin errors++; $display("FAIL wrap_count%0d: got %0d expected 1", i, count); end
      end
      idle();
      #1;
      checks++; if ({we, waddr, wdata} !== {1'b1, 5'd18, 32'd207}) begin errors++; $display("FAIL wrap_last: got we=%0b waddr=%0d wdata=%0d expected 1/18/207", we, waddr, wdata); end
      cyc();
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %0b expected 1", empty); end
      for (int k = 11; k <= 18; k++) begin
         checks++; if (rf[k] !== 32'(189 + k)) begin errors++; $display("FAIL wrap_rf%0d: got %0d expected %0d", k, rf[k], 189 + k); end
      end
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 3; k++) begin
         alu_we = 1'b1; alu_waddr = 5'd21; alu_wdata = 32'd55;
         lu_valid = 1'b1; lu_waddr = 5'(12 + k); lu_wdata = 32'(300 + k);
         cyc();
      end
      lu_valid = 1'b0;
      checks++; if (count !== 3'd3) begin errors++; $display("FAIL rstmid_pre_count: got %0d expected 3", count); end
      #3;
      rst = 1'b1;
      #1;
      checks++; if ({we, waddr, wdata} !== {1'b0, 5'd0, 32'd0}) begin errors++; $display("FAIL rstmid_port: got we=%0b waddr=%0d wdata=%0d expected 0/0/0", we, waddr, wdata); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL rstmid_count: got %0d expected 0", count); end
      checks++; if (pending !== 32'd0) begin errors++; $display("FAIL rstmid_pending: got %0h expected 0", pending); end
      checks++; if ({empty, full, lu_ready} !== 3'b100) begin errors++; $display("FAIL rstmid_flags: got empty/full/ready=%0b%0b%0b expected 100", empty, full, lu_ready); end
      cyc();
      rst = 1'b0;
      idle();
      #1;
      checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %0b expected 1", lu_ready); end
      checks++; if (count !== 3'd0) begin errors++; $display("FAIL rstmid_post_count: got %0d expected 0", count); end
   endtask

   initial begin
      test_reset();
      test_alu_priority();
      test_full();
      test_waw_kill();
      test_zero();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Write-side front end for the MIPS register file: merges the single-cycle ALU writeback and a long-latency writeback source (mult/div, load) onto the register file's single write port (`we`/`waddr`/`wdata`). The ALU has priority. Long-latency results are buffered in a small FIFO with per-entry kill. A per-register pending vector lets decode stall on buffered writes. It sits between the writeback stage and the register file and owns every register-file write.

## Interface

**Parameters**
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `AW`, 5: register address width.
- `DW`, 32: data width.

**Ports**
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `alu_we` in 1: ALU writeback valid.
- `alu_waddr` in AW: ALU destination register.
- `alu_wdata` in DW: ALU result.
- `lu_valid` in 1: long-latency result valid.
- `lu_ready` out 1: long-latency result accepted this cycle.
- `lu_waddr` in AW: long-latency destination register.
- `lu_wdata` in DW: long-latency result.
- `we` out 1: register-file write enable.
- `waddr` out AW: register-file write address.
- `wdata` out DW: register-file write data.
- `pending` out 2^AW: bit r set while a live buffered write to register r exists.
- `count` out log2(DEPTH)+1: number of occupied entries, live or killed.
- `full` out 1: count == DEPTH.
- `empty` out 1: count == 0.

## Operation

- **ALU path.** `alu_we` with `alu_waddr` ≠ 0 drives `we=1`, `waddr=alu_waddr`, `wdata=alu_wdata` combinationally. Writes to $zero are dropped: `we=0` for that source.
- **Enqueue.** Occurs when `lu_valid && lu_ready`.
  - `lu_ready = !full && !rst`.
  - No enqueue while full, even if a pop happens in the same cycle.
  - `lu_waddr` = 0 is accepted (handshake completes) but not stored.
- **Drain.** The head entry pops in a cycle when any of these holds:
  - the head is killed: it pops with no write, regardless of ALU activity;
  - the head is live and the ALU is not writing (no `alu_we`, or `alu_waddr` = 0): the head drives `we=1`, `waddr`, `wdata` and pops.
  - A live head is held while the ALU writes. There is no starvation guard; upstream stalls on `!lu_ready`.
- **WAW kill.** When the ALU writes register r, every entry already in the FIFO with address r gets its kill bit set at that edge. An entry enqueued in the same cycle is younger and is not killed.
- **`pending`.** OR-decode of the addresses of live (unkilled) entries. It updates at the same edge as enqueue, kill, and pop. Bit 0 is always 0.
- **Arithmetic.** Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. `count` is tracked separately: +1 on enqueue, −1 on pop, unchanged when both occur.

## Timing

- ALU write: zero added latency; the register file captures it at the next edge.
- Buffered write: an entry enqueued at edge N can drive the port at the earliest in the cycle after edge N, so the register file captures it at edge N+1.
- Pop and enqueue may occur in the same cycle when not full.
- **Reset (asynchronous)**, effective immediately on `rst` assertion:
  - `we`=0, `waddr`=0, `wdata`=0, `pending`=0, `count`=0, `empty`=1, `full`=0, `lu_ready`=0;
  - pointers and kill bits cleared; entries in flight are discarded.
  - Reset mid-drain loses the buffered writes; this is acceptable because the pipeline is flushed on reset.
- `lu_ready` rises in the first cycle after `rst` deasserts.

## Structure

- **Shared package `mips_pkg`:** AW, DW, the `REG_ZERO` constant (5'd0), and the writeback-entry struct {addr, data, kill}.
- **Sub-module `wb_fifo`:** circular buffer with push/pop, a per-entry address compare for kill-on-match, and live-address decode to `pending`.
- **Top level:** source-priority mux and `$zero` filtering.

## Test plan

1. **ALU priority.** `alu_we`=1, `alu_waddr`=16, `alu_wdata`=1337 while the FIFO holds a live entry (9, 69) → `we`/16/1337 this cycle; the entry is written in the next idle ALU cycle, so register 9 = 69.
2. **Full.** Enqueue four entries (regs 1–4) with the ALU busy on reg 20 → `full`=1, `lu_ready`=0, `pending`=0x1E. The fifth `lu_valid` is held until one idle cycle pops reg 1.
3. **WAW kill.**
   - FIFO holds (7, 5). ALU writes (7, 99) → `pending[7]` clears at that edge. The entry later pops with `we`=0, and register 7 stays 99.
   - Same-cycle case: enqueue (7, 5) together with the ALU write → the entry is not killed and register 7 ends at 5.
4. **$zero.** `alu_waddr`=0 or `lu_waddr`=0 → `we`=0. `lu_ready` handshake completes and `count` is unchanged.
5. **Wrap-around.** Eight back-to-back enqueues, each with a simultaneous pop → writes arrive in order, with `count` steady at 1 after the first.
6. **Async reset mid-operation.** Assert `rst` between edges with `count`=3 → `we`=0, `count`=0, `pending`=0 immediately. After deassert, `lu_ready`=1 in the next cycle.
